// File: rtl/dino_pkg.sv
// Shared constants and helpers for the dino runner obstacle logic.
// Obstacle type codes, screen width and the offscreen position helper.
package dino_pkg;

    localparam int SCREEN_W = 640;

    localparam logic [2:0] OBS_CACTUS_S = 3'd0;
    localparam logic [2:0] OBS_CACTUS_L = 3'd1;
    localparam logic [2:0] OBS_CACTUS_G = 3'd2;
    localparam logic [2:0] OBS_BIRD_LO  = 3'd3;
    localparam logic [2:0] OBS_BIRD_HI  = 3'd4;

    // All-ones position of width pw, right-aligned in 10 bits
    function automatic logic [9:0] offscreen(input int pw);
        return 10'h3FF >> (10 - pw);
    endfunction

    function automatic logic [2:0] wrap_type(input logic [2:0] r, input int nt);
        logic [3:0] n;
        n = 4'(nt);
        if ({1'b0, r} < n) return r;
        return 3'({1'b0, r} - n);
    endfunction

endpackage

// File: rtl/obstacle_slot.sv
// One obstacle slot: position, type and occupancy, scrolled per tick.
// A slot retiring on a tick only reports free from the following cycle.
module obstacle_slot
    import dino_pkg::*;
#(
    parameter int CONV = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_i,
    input  logic          clear_i,
    input  logic          load_i,
    input  logic [2:0]    load_type_i,
    input  logic [2:0]    speed_i,
    output logic [9-CONV:0] pos_o,
    output logic [2:0]    type_o,
    output logic          active_o,
    output logic          free_o
);

    localparam int PW = 10 - CONV;
    localparam logic [9:0] OFF_W = offscreen(PW);
    localparam logic [PW-1:0] OFFSCREEN = OFF_W[PW-1:0];
    localparam logic [PW-1:0] SPAWN_X = PW'((SCREEN_W >> CONV) - 1);

    logic [PW-1:0] pos_q, pos_d;
    logic [2:0]    type_q, type_d;
    logic          active_q, active_d;
    logic [PW:0]   diff;

    // Borrow out of the extra bit means pos < speed
    assign diff = {1'b0, pos_q} - {{(PW-2){1'b0}}, speed_i};

    always_comb begin
        pos_d    = pos_q;
        type_d   = type_q;
        active_d = active_q;
        if (clear_i) begin
            pos_d    = OFFSCREEN;
            type_d   = 3'd0;
            active_d = 1'b0;
        end else if (tick_i) begin
            if (active_q) begin
                if (diff[PW]) begin
                    pos_d    = OFFSCREEN;
                    type_d   = 3'd0;
                    active_d = 1'b0;
                end else begin
                    pos_d = diff[PW-1:0];
                end
            end else if (load_i) begin
                pos_d    = SPAWN_X;
                type_d   = load_type_i;
                active_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q    <= OFFSCREEN;
            type_q   <= 3'd0;
            active_q <= 1'b0;
        end else begin
            pos_q    <= pos_d;
            type_q   <= type_d;
            active_q <= active_d;
        end
    end

    assign pos_o    = pos_q;
    assign type_o   = type_q;
    assign active_o = active_q;
    assign free_o   = ~active_q;

endmodule

// File: rtl/obstacle_pool.sv
// Pool of NUM_OBS scrolling obstacles with LFSR-randomised spawn gaps.
// Speed ramp is built only when OBSTACLE_POOL_SPEED_RAMP_EN is defined.
module obstacle_pool
    import dino_pkg::*;
#(
    parameter int NUM_OBS   = 2,
    parameter int CONV      = 2,
    parameter int NUM_TYPES = 5,
    parameter int MIN_GAP   = 24,
    parameter int MAX_SPEED = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       game_tick,
    input  logic                       game_start,
    input  logic                       game_frozen,
    input  logic                       speed_up,
    input  logic [7:0]                 rng,
    output logic [NUM_OBS*(10-CONV)-1:0] obs_pos,
    output logic [NUM_OBS*3-1:0]       obs_type,
    output logic [NUM_OBS-1:0]         obs_active,
    output logic [2:0]                 speed
);

    localparam int PW = 10 - CONV;
    localparam int GW = $clog2(MIN_GAP + 32);

    logic               tick_en;
    logic [NUM_OBS-1:0] free;
    logic [NUM_OBS-1:0] load_sel;
    logic               found;
    logic               spawn;
    logic [GW-1:0]      gap_q, gap_d, gap_dec;
    logic [2:0]         spawn_type;

    assign tick_en    = game_tick & ~game_frozen & ~game_start;
    assign gap_dec    = (gap_q != '0) ? gap_q - 1'b1 : '0;
    assign spawn      = tick_en & (gap_dec == '0) & (|free);
    assign spawn_type = wrap_type(rng[2:0], NUM_TYPES);

    always_comb begin
        load_sel = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_OBS; i++) begin
            if (free[i] && !found) begin
                load_sel[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    always_comb begin
        gap_d = gap_q;
        if (game_start) begin
            gap_d = GW'(MIN_GAP);
        end else if (tick_en) begin
            gap_d = spawn ? GW'(MIN_GAP) + GW'(rng[7:3]) : gap_dec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) gap_q <= GW'(MIN_GAP);
        else     gap_q <= gap_d;
    end

`ifdef OBSTACLE_POOL_SPEED_RAMP_EN
    logic [2:0] speed_q, speed_d;

    always_comb begin
        speed_d = speed_q;
        if (game_start) begin
            speed_d = 3'd1;
        end else if (speed_up && !game_frozen && speed_q < 3'(MAX_SPEED)) begin
            speed_d = speed_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) speed_q <= 3'd1;
        else     speed_q <= speed_d;
    end

    assign speed = speed_q;
`else
    logic unused_speed_up;
    assign unused_speed_up = speed_up;
    assign speed = 3'd1;
`endif

    for (genvar g = 0; g < NUM_OBS; g++) begin : g_slot
        obstacle_slot #(
            .CONV(CONV)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .tick_i     (tick_en),
            .clear_i    (game_start),
            .load_i     (spawn & load_sel[g]),
            .load_type_i(spawn_type),
            .speed_i    (speed),
            .pos_o      (obs_pos[g*PW +: PW]),
            .type_o     (obs_type[g*3 +: 3]),
            .active_o   (obs_active[g]),
            .free_o     (free[g])
        );
    end

endmodule

// File: tb/tb_obstacle_pool.sv
// Directed self-checking bench for obstacle_pool at default parameters.
// Expectations follow the OBSTACLE_POOL_SPEED_RAMP_EN setting of the build.
module tb_obstacle_pool;

    logic        clk = 1'b0;
    logic        rst;
    logic        game_tick;
    logic        game_start;
    logic        game_frozen;
    logic        speed_up;
    logic [7:0]  rng;
    logic [15:0] obs_pos;
    logic [5:0]  obs_type;
    logic [1:0]  obs_active;
    logic [2:0]  speed;

    int n_checks = 0;
    int n_errors = 0;
    int exp_spd;

    obstacle_pool dut (
        .clk        (clk),
        .rst        (rst),
        .game_tick  (game_tick),
        .game_start (game_start),
        .game_frozen(game_frozen),
        .speed_up   (speed_up),
        .rng        (rng),
        .obs_pos    (obs_pos),
        .obs_type   (obs_type),
        .obs_active (obs_active),
        .speed      (speed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input logic [7:0] r);
        @(negedge clk);
        rng       = r;
        game_tick = 1'b1;
        @(negedge clk);
        game_tick = 1'b0;
    endtask

    task automatic ticks(input int n, input logic [7:0] r);
        for (int i = 0; i < n; i++) tick(r);
    endtask

    initial begin
        rst         = 1'b1;
        game_tick   = 1'b0;
        game_start  = 1'b0;
        game_frozen = 1'b0;
        speed_up    = 1'b0;
        rng         = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_active", obs_active, 2'b00);
        chk("rst_pos", obs_pos, 16'hFFFF);
        chk("rst_type", obs_type, 6'd0);
        chk("rst_speed", speed, 3'd1);

        @(negedge clk) game_start = 1'b1;
        @(negedge clk) game_start = 1'b0;

        ticks(23, 8'h00);
        chk("gap_23_idle", obs_active, 2'b00);
        tick(8'hFF);
        chk("spawn0_active", obs_active, 2'b01);
        chk("spawn0_pos", obs_pos[7:0], 8'd159);
        chk("spawn0_type_wrap", obs_type[2:0], 3'd2);
        chk("slot1_idle_pos", obs_pos[15:8], 8'hFF);

        ticks(54, 8'h00);
        chk("gap55_pending", obs_active, 2'b01);
        chk("scroll_pos0", obs_pos[7:0], 8'd105);
        tick(8'h03);
        chk("spawn1_active", obs_active, 2'b11);
        chk("spawn1_pos", obs_pos[15:8], 8'd159);
        chk("spawn1_type", obs_type[5:3], 3'd3);
        chk("scroll_pos0_b", obs_pos[7:0], 8'd104);

        ticks(24, 8'h00);
        chk("full_no_spawn", obs_active, 2'b11);
        chk("full_pos", obs_pos, {8'd135, 8'd80});

        ticks(80, 8'h00);
        chk("pos0_zero", obs_pos[7:0], 8'd0);
        chk("pos0_zero_act", obs_active, 2'b11);
        tick(8'h00);
        chk("retire_active", obs_active, 2'b10);
        chk("retire_pos", obs_pos, {8'd54, 8'hFF});
        chk("retire_type", obs_type[2:0], 3'd0);
        tick(8'h06);
        chk("respawn_active", obs_active, 2'b11);
        chk("respawn_pos", obs_pos, {8'd53, 8'd159});
        chk("respawn_type", obs_type, {3'd3, 3'd1});

        @(negedge clk) game_frozen = 1'b1;
        for (int i = 0; i < 100; i++) begin
            speed_up = (i % 10 == 0);
            tick(8'hFF);
        end
        speed_up = 1'b0;
        chk("frz_pos", obs_pos, {8'd53, 8'd159});
        chk("frz_active", obs_active, 2'b11);
        chk("frz_type", obs_type, {3'd3, 3'd1});
        chk("frz_speed", speed, 3'd1);

        @(negedge clk);
        game_start = 1'b1;
        game_tick  = 1'b1;
        @(negedge clk);
        game_start = 1'b0;
        game_tick  = 1'b0;
        chk("frz_start_active", obs_active, 2'b00);
        chk("frz_start_pos", obs_pos, 16'hFFFF);
        chk("frz_start_type", obs_type, 6'd0);
        game_frozen = 1'b0;

        ticks(23, 8'h00);
        chk("start_gap_idle", obs_active, 2'b00);
        tick(8'h02);
        chk("start_gap_spawn", obs_active, 2'b01);
        chk("start_gap_type", obs_type[2:0], 3'd2);

        exp_spd = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk) speed_up = 1'b1;
            @(negedge clk) speed_up = 1'b0;
`ifdef OBSTACLE_POOL_SPEED_RAMP_EN
            exp_spd = (exp_spd < 3) ? exp_spd + 1 : 3;
`endif
            chk("ramp_speed", speed, exp_spd);
        end
        tick(8'h00);
        chk("ramp_step", obs_pos[7:0], 159 - exp_spd);

        @(negedge clk);
        game_start = 1'b1;
        game_tick  = 1'b1;
        speed_up   = 1'b1;
        @(negedge clk);
        game_start = 1'b0;
        game_tick  = 1'b0;
        speed_up   = 1'b0;
        chk("prio_speed", speed, 3'd1);
        chk("prio_active", obs_active, 2'b00);

        ticks(24, 8'h00);
        chk("mid_spawn", obs_active, 2'b01);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("mid_rst_active", obs_active, 2'b00);
        chk("mid_rst_pos", obs_pos, 16'hFFFF);
        ticks(23, 8'h00);
        chk("mid_rst_gap", obs_active, 2'b00);
        tick(8'h00);
        chk("mid_rst_spawn", obs_active, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
